// File: rtl/rtx_pixel_accumulator_pkg.sv
// Shared types for the pixel accumulator: fp24 colour types, RGB888 pixel,
// FSM state encoding and the per-channel EMA blend helper.
package rtx_pixel_accumulator_pkg;

  typedef logic [23:0] fp24;

  typedef struct packed {
    fp24 r;
    fp24 g;
    fp24 b;
  } fp24_vec3;

  localparam fp24 FP24_ONE      = 24'h3f0000;
  localparam int  FP24_EXP_BIAS = 63;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    WAIT  = 3'd2,
    BLEND = 3'd3,
    WRITE = 3'd4
  } state_t;

  // new = old + ((sample - old) >>> k); the floor shift keeps the result in [0,255].
  function automatic logic [7:0] ema_channel(input logic [7:0] old,
                                             input logic [7:0] sample,
                                             input logic [2:0] k);
    logic signed [8:0] diff;
    logic signed [8:0] step;
    logic signed [8:0] sum;
    diff = $signed({1'b0, sample}) - $signed({1'b0, old});
    step = diff >>> k;
    sum  = $signed({1'b0, old}) + step;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/rtx_pixel_accumulator_if.sv
// Pixel hand-off from the ray tracer into the accumulator.
interface rtx_pixel_accumulator_if;
  // A sample is taken on a rising clk edge where in_valid && in_ready. in_valid is a
  // one-cycle pulse and is not held: a pulse seen while in_ready is low is dropped.
  // color/h/v/first_frame/blend_shift only need to be stable in the in_valid cycle.
  logic        in_valid;
  logic [71:0] in_color;
  logic [10:0] in_h;
  logic [9:0]  in_v;
  logic        in_ready;
  logic        first_frame;
  logic [2:0]  blend_shift;

  modport master (
    output in_valid, in_color, in_h, in_v, first_frame, blend_shift,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_color, in_h, in_v, first_frame, blend_shift,
    output in_ready
  );
endinterface

// File: rtl/rtx_pixel_accumulator_fp24_to_u8.sv
// Combinational fp24 (1/7/16, bias 63) to unsigned 8-bit converter.
// Negatives clamp to 0, values >= 1.0 saturate to 255.
module fp24_to_u8
  import rtx_pixel_accumulator_pkg::*;
(
  input  fp24        value,
  output logic [7:0] u8
);

  logic [6:0]  exp_f;
  logic [15:0] man;
  logic [6:0]  s;

  always_comb begin
    exp_f = value[22:16];
    man   = value[15:0];
    s     = 7'(FP24_EXP_BIAS) - exp_f;
    u8    = 8'd0;
    if (value[23] || (value[22:0] == 23'd0)) begin
      u8 = 8'd0;
    end else if (exp_f >= 7'(FP24_EXP_BIAS)) begin
      u8 = 8'hff;
    end else if (s > 7'd16) begin
      u8 = 8'd0;
    end else begin
      u8 = 8'((({1'b1, man}) >> s) >> 8);
    end
  end

endmodule

// File: rtl/rtx_pixel_accumulator.sv
// Converts finished fp24 pixels to RGB888 and read-modify-writes a per-pixel EMA
// into the accumulation BRAM. Define RTX_ACCUM_PERF_EN for accept/drop counters.
module rtx_pixel_accumulator
  import rtx_pixel_accumulator_pkg::*;
#(
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 720,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_W       = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  rtx_pixel_accumulator_if.slave pix,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [23:0]           rd_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [23:0]           wr_data,
  output state_t                state
`ifdef RTX_ACCUM_PERF_EN
  ,
  output logic [31:0]           accepted_count,
  output logic [31:0]           dropped_count
`endif
);

  localparam int CNT_W = $clog2(BRAM_LATENCY + 1);
  // rd_en is registered out of CONV, so read data lands BRAM_LATENCY cycles after WAIT starts.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BRAM_LATENCY - 1);

  state_t            state_next;
  logic              ready_q;
  logic              accept;
  fp24_vec3          color_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] in_addr;
  logic              first_q;
  logic [2:0]        k_q;
  rgb888             sample_q;
  rgb888             conv;
  rgb888             old_px;
  logic [7:0]        conv_r;
  logic [7:0]        conv_g;
  logic [7:0]        conv_b;
  logic [CNT_W-1:0]  wait_cnt;

  assign pix.in_ready = ready_q;
  assign accept       = pix.in_valid && ready_q;
  assign in_addr      = ADDR_W'(pix.in_v) * ADDR_W'(WIDTH) + ADDR_W'(pix.in_h);
  assign conv         = {conv_r, conv_g, conv_b};
  assign old_px       = rd_data;

  fp24_to_u8 u_conv_r (.value(color_q.r), .u8(conv_r));
  fp24_to_u8 u_conv_g (.value(color_q.g), .u8(conv_g));
  fp24_to_u8 u_conv_b (.value(color_q.b), .u8(conv_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CONV;
      CONV:    state_next = first_q ? WRITE : WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = BLEND;
      BLEND:   state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b1;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      color_q  <= '0;
      addr_q   <= '0;
      first_q  <= 1'b0;
      k_q      <= '0;
      sample_q <= '0;
      wait_cnt <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            color_q <= pix.in_color;
            addr_q  <= in_addr;
            first_q <= pix.first_frame;
            k_q     <= pix.blend_shift;
            ready_q <= 1'b0;
          end
        end
        CONV: begin
          sample_q <= conv;
          wait_cnt <= '0;
          if (first_q) begin
            wr_data <= conv;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= addr_q;
          end
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        BLEND: begin
          wr_data <= {ema_channel(old_px.r, sample_q.r, k_q),
                      ema_channel(old_px.g, sample_q.g, k_q),
                      ema_channel(old_px.b, sample_q.b, k_q)};
        end
        WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= addr_q;
          ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RTX_ACCUM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_count <= '0;
      dropped_count  <= '0;
    end else begin
      if (accept)                     accepted_count <= accepted_count + 32'd1;
      if (pix.in_valid && !ready_q)   dropped_count  <= dropped_count + 32'd1;
    end
  end
`endif

endmodule
